// File: rtl/ones_pattern_tx.sv
// Bit-serial thermometer generator: accepts a ones count and shifts out an
// 8-bit LSB-aligned pattern with that many ones. ONES_PATTERN_TX_PARITY_EN adds an even-parity bit.
module ones_pattern_tx #(
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         cnt_in,
  input  logic               cnt_valid,
  output logic               cnt_ready,
  output logic               ser_out,
  output logic               ser_valid,
  output logic [FRAME_W-1:0] dat_out,
  output logic               done,
  output logic               err_sat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef ONES_PATTERN_TX_PARITY_EN
    , S_PAR = 2'd3
`endif
  } state_t;

  state_t             state;
  logic [2:0]         idx;
  logic [FRAME_W-1:0] sr;
  logic [3:0]         n_clamp;
  logic               clamped;
  logic [FRAME_W-1:0] pat;
`ifdef ONES_PATTERN_TX_PARITY_EN
  logic               par_bit;
`endif

  assign clamped = (cnt_in > 4'd8);
  assign n_clamp = clamped ? 4'd8 : cnt_in;

  // Thermometer: bit i is set when i < n, same as (1<<n)-1 truncated to 8 bits.
  always_comb begin
    pat = '0;
    for (int i = 0; i < FRAME_W; i++)
      pat[i] = (4'(i) < n_clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_ready <= 1'b1;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      dat_out   <= '0;
      done      <= 1'b0;
      err_sat   <= 1'b0;
      idx       <= 3'd0;
      sr        <= '0;
`ifdef ONES_PATTERN_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      err_sat <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cnt_valid && cnt_ready) begin
            // Bit 0 goes straight to the output register; sr keeps the remainder.
            sr        <= pat >> 1;
            dat_out   <= pat;
            ser_out   <= pat[0];
            ser_valid <= 1'b1;
            cnt_ready <= 1'b0;
            err_sat   <= clamped;
            idx       <= 3'd0;
            state     <= S_SHIFT;
`ifdef ONES_PATTERN_TX_PARITY_EN
            par_bit   <= n_clamp[0];
`endif
          end
        end
        S_SHIFT: begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef ONES_PATTERN_TX_PARITY_EN
            ser_out <= par_bit;
            state   <= S_PAR;
`else
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
`endif
          end else begin
            ser_out <= sr[0];
            sr      <= sr >> 1;
          end
        end
`ifdef ONES_PATTERN_TX_PARITY_EN
        S_PAR: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          cnt_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_pattern_tx.sv
// Self-checking bench for ones_pattern_tx against a frame-level reference model.
module tb_ones_pattern_tx;
`ifdef ONES_PATTERN_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_valid = 1'b0;
  logic       cnt_ready, ser_out, ser_valid, done, err_sat;
  logic [7:0] dat_out;

  int checks = 0;
  int errors = 0;

  logic [FL+1:0] r_sv, r_so, r_done, r_rdy, r_err;
  logic [7:0]    r_dat [0:FL+1];

  ones_pattern_tx #(.FRAME_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .dat_out(dat_out), .done(done), .err_sat(err_sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampn(int c);
    return (c > 8) ? 8 : c;
  endfunction

  function automatic logic [7:0] model_pat(int c);
    int v;
    v = (1 << clampn(c)) - 1;
    return v[7:0];
  endfunction

  // Expected serial stream: pattern bits LSB first, then (optionally) parity.
  function automatic logic exp_bit(int c, int i);
    logic [7:0] p;
    p = model_pat(c);
    if (i < 8) return p[i];
    return (clampn(c) % 2) == 1;
  endfunction

  // Accept c at the next edge and record cycles T+1 .. T+FL+2.
  // Returns in the cnt_ready cycle, before its closing edge.
  task automatic record_frame(input int c, input bit hold, input int chg);
    cnt_in    = 4'(c);
    cnt_valid = 1'b1;
    tick();
    if (!hold) cnt_valid = 1'b0;
    for (int i = 0; i <= FL + 1; i++) begin
      r_sv[i] = ser_valid; r_so[i] = ser_out; r_done[i] = done;
      r_rdy[i] = cnt_ready; r_err[i] = err_sat; r_dat[i] = dat_out;
      if (i == 1 && hold) cnt_in = 4'($urandom_range(0, 15));
      if (i == 2 && chg >= 0) cnt_in = 4'(chg);
      if (i < FL + 1) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_valid = 1'b1; cnt_in = 4'd3;
    tick(); tick();
    checks++;
    if ({cnt_ready, ser_valid, ser_out, done, err_sat, dat_out} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL reset: rdy/sv/so/done/err/dat=%b %b %b %b %b %h required 1 0 0 0 0 00",
               cnt_ready, ser_valid, ser_out, done, err_sat, dat_out);
    end
    rst = 1'b0; cnt_valid = 1'b0;
    tick();
    checks++;
    if ({cnt_ready, ser_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_no_accept: rdy=%b sv=%b required 1 0", cnt_ready, ser_valid);
    end
  endtask

  task automatic test_zero();
    record_frame(0, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({r_sv[i], r_so[i], r_dat[i]} !== {2'b10, 8'h00}) begin
        errors++;
        $display("FAIL zero_bit%0d: sv=%b so=%b dat=%h required 1 0 00", i, r_sv[i], r_so[i], r_dat[i]);
      end
    end
    checks++;
    if (r_done[FL] !== 1'b1 || r_sv[FL] !== 1'b0 || r_done[FL+1] !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done@T+%0d=%b sv=%b done_after=%b required 1 0 0",
               FL + 1, r_done[FL], r_sv[FL], r_done[FL+1]);
    end
    checks++;
    if (|r_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_err_sat: err trace=%b required all 0", r_err);
    end
  endtask

  task automatic test_three();
    logic [7:0] exp_ser;
    exp_ser = 8'b0000_0111;
    record_frame(3, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_so[i] !== exp_ser[i] || r_sv[i] !== 1'b1) begin
        errors++;
        $display("FAIL three_bit%0d: so=%b sv=%b required %b 1", i, r_so[i], r_sv[i], exp_ser[i]);
      end
    end
    checks++;
    if (r_dat[0] !== 8'h07) begin
      errors++;
      $display("FAIL three_dat: dat=%h required 07", r_dat[0]);
    end
`ifdef ONES_PATTERN_TX_PARITY_EN
    checks++;
    if (r_sv[8] !== 1'b1 || r_so[8] !== 1'b1) begin
      errors++;
      $display("FAIL three_parity: sv=%b so=%b required 1 1", r_sv[8], r_so[8]);
    end
`endif
    checks++;
    if (r_done[FL] !== 1'b1 || r_rdy[FL+1] !== 1'b1) begin
      errors++;
      $display("FAIL three_done: done=%b rdy_next=%b required 1 1", r_done[FL], r_rdy[FL+1]);
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c <= 8; c++) begin
      int ones;
      record_frame(c, 1'b1, -1);
      ones = 0;
      for (int i = 0; i <= FL + 1; i++) begin
        logic [12:0] exp_v, got_v;
        exp_v = {i < FL, (i < FL) ? exp_bit(c, i) : 1'b0, i == FL, i == FL + 1, 1'b0, model_pat(c)};
        got_v = {r_sv[i], r_so[i], r_done[i], r_rdy[i], r_err[i], r_dat[i]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL sweep_c%0d_cyc%0d: sv/so/done/rdy/err/dat=%b required %b", c, i + 1, got_v, exp_v);
        end
        if (i < 8 && r_sv[i] && r_so[i]) ones++;
      end
      checks++;
      if (ones != c) begin
        errors++;
        $display("FAIL sweep_tally_c%0d: ones=%0d required %0d", c, ones, c);
      end
    end
    cnt_valid = 1'b0;
    tick();
  endtask

  task automatic test_sat();
    int ones;
    record_frame(12, 1'b0, -1);
    checks++;
    if (r_err[0] !== 1'b1 || |r_err[FL+1:1] !== 1'b0) begin
      errors++;
      $display("FAIL sat_err: err trace=%b required pulse at T+1 only", r_err);
    end
    checks++;
    if (r_dat[0] !== 8'hFF) begin
      errors++;
      $display("FAIL sat_dat: dat=%h required ff", r_dat[0]);
    end
    ones = 0;
    for (int i = 0; i < 8; i++) if (r_sv[i] && r_so[i]) ones++;
    checks++;
    if (ones != 8) begin
      errors++;
      $display("FAIL sat_tally: ones=%0d required 8", ones);
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    cnt_in = 4'd5; cnt_valid = 1'b1;
    tick();
    cnt_valid = 1'b0;
    tick(); tick(); tick();   // now in cycle T+4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ser_valid, ser_out, dat_out, cnt_ready, done} !== {2'b00, 8'h00, 2'b10}) begin
      errors++;
      $display("FAIL rst_mid: sv=%b so=%b dat=%h rdy=%b done=%b required 0 0 00 1 0",
               ser_valid, ser_out, dat_out, cnt_ready, done);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || ser_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: done/ser_valid seen %0d cycles required 0", seen);
    end
  endtask

  task automatic test_cnt_change();
    record_frame(2, 1'b0, 7);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r_dat[i] !== 8'h03 || r_so[i] !== exp_bit(2, i)) begin
        errors++;
        $display("FAIL chg_cyc%0d: dat=%h so=%b required 03 %b", i + 1, r_dat[i], r_so[i], exp_bit(2, i));
      end
    end
    tick();
    checks++;
    if ({cnt_ready, ser_valid, dat_out} !== {2'b10, 8'h03}) begin
      errors++;
      $display("FAIL chg_idle: rdy=%b sv=%b dat=%h required 1 0 03", cnt_ready, ser_valid, dat_out);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int c;
      bit hold;
      int ones;
      c = $urandom_range(0, 15);
      hold = 1'($urandom_range(0, 1));
      record_frame(c, hold, -1);
      ones = 0;
      for (int i = 0; i <= FL + 1; i++) begin
        logic [12:0] exp_v, got_v;
        exp_v = {i < FL, (i < FL) ? exp_bit(c, i) : 1'b0, i == FL, i == FL + 1,
                 (i == 0) && (c > 8), model_pat(c)};
        got_v = {r_sv[i], r_so[i], r_done[i], r_rdy[i], r_err[i], r_dat[i]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL rand_f%0d_c%0d_cyc%0d: sv/so/done/rdy/err/dat=%b required %b", f, c, i + 1, got_v, exp_v);
        end
        if (i < 8 && r_sv[i] && r_so[i]) ones++;
      end
      checks++;
      if (ones != clampn(c)) begin
        errors++;
        $display("FAIL rand_tally_f%0d: ones=%0d required %0d", f, ones, clampn(c));
      end
      if (!hold) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          tick();
          checks++;
          if ({cnt_ready, ser_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rand_idle_f%0d: rdy=%b sv=%b required 1 0", f, cnt_ready, ser_valid);
          end
        end
      end
    end
    cnt_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_three();
    test_sweep();
    test_sat();
    test_rst_mid();
    test_cnt_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_pattern_tx.md
# ones_pattern_tx

Bit-serial generator for the inverse of the ones-count function. It accepts a 4-bit ones count over a valid/ready handshake and builds the 8-bit thermometer pattern with exactly that many ones, LSB-aligned. It then shifts the pattern out one bit per clock, LSB first, and flags frame completion. It feeds links and benches whose receiving end runs the combinational ones counter, so `count(dat_out) == cnt_in` must hold for every accepted value 0..8.

## Interface
- `FRAME_W`, 8: pattern width in bits; fixed at 8, present for documentation only.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cnt_in`  in  4  requested number of ones; values 0..8 are legal.
- `cnt_valid`  in  1  `cnt_in` is valid.
- `cnt_ready`  out  1  block can accept a count; high only in IDLE.
- `ser_out`  out  1  serial data bit; 0 when `ser_valid` is low.
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle.
- `dat_out`  out  8  parallel copy of the current or last pattern; held until the next accept.
- `done`  out  1  one-cycle pulse after the last frame bit.
- `err_sat`  out  1  one-cycle pulse: the accepted `cnt_in` was greater than 8 and was clamped.

## Operation
- Reset values: state IDLE, `cnt_ready`=1, `ser_out`=0, `ser_valid`=0, `dat_out`=8'h00, `done`=0, `err_sat`=0, bit index=0.
- State machine: IDLE -> SHIFT -> (PAR) -> DONE -> IDLE.
- IDLE: accept when `cnt_valid && cnt_ready`.
  - Clamp: n = (cnt_in > 8) ? 8 : cnt_in.
  - Load the shift register and `dat_out` with (1<<n)-1, computed in 9-bit width then truncated to 8, so n=8 gives 8'hFF.
  - Pulse `err_sat` in the next cycle if clamped.
  - Go to SHIFT.
- SHIFT: for 8 cycles, `ser_valid`=1 and `ser_out` = shift register bit 0. Shift right, filling with 0; a 3-bit index wraps 7 -> 0.
  - At index 7, go to PAR if the macro is defined, otherwise go to DONE.
- PAR (macro only): one cycle, `ser_valid`=1, `ser_out` = even-parity bit = XOR of the pattern = n[0].
- DONE: one cycle, `done`=1, `ser_valid`=0; then go to IDLE.
- `cnt_valid` outside IDLE is ignored; it is neither queued nor acknowledged. Upstream holds it until `cnt_ready`.
- `cnt_in` is sampled only on the accepting edge; changes mid-frame have no effect.
- Reset mid-frame: the block returns to reset values on the next edge. The frame is abandoned with no `done` and no further `ser_valid`.

## Timing
- Accept on edge T (IDLE, valid && ready):
  - `cnt_ready` falls after T.
  - Bits 0..7 appear in cycles T+1..T+8.
  - `err_sat` (if set) appears in cycle T+1.
- Without the macro: `done` in cycle T+9; `cnt_ready` high again in T+10.
- With the macro: parity bit in cycle T+9, `done` in T+10, `cnt_ready` in T+11.
- Back-to-back with `cnt_valid` held high: the next accept occurs at the end of the first `cnt_ready` cycle. The gap between frames is 2 cycles with no `ser_valid`.
- `dat_out` updates on the accepting edge, so it is visible from T+1, and is stable for the whole frame.
- `rst` and `cnt_valid` asserted together: reset wins and nothing is accepted.

## Configuration
- `ONES_PATTERN_TX_PARITY_EN`:
  - Defined: a 9th serial bit is sent, the even parity of the pattern (equals n[0]). The frame is 9 bits and `done` is at T+10.
  - Undefined: the PAR state and parity logic are absent. The frame is 8 bits and `done` is at T+9.

## Test plan
- Reset, then `cnt_in`=0 with valid -> 8 cycles of `ser_valid`=1 with `ser_out`=0, `dat_out`=8'b0000_0000, `done` at T+9, `err_sat` never high.
- `cnt_in`=3 -> serial 1,1,1,0,0,0,0,0 (LSB first), `dat_out`=8'b0000_0111. With the macro, the 9th bit is 1 and `done` is at T+10.
- Sweep 0..8 back-to-back with valid held -> `dat_out` follows 00, 01, 03, 07, 0F, 1F, 3F, 7F, FF. Each frame has a 2-cycle gap and the serial ones tally equals the count for each frame.
- `cnt_in`=12 -> `err_sat` pulse at T+1, `dat_out`=8'hFF, eight serial ones.
- `rst` asserted at T+4 of a `cnt_in`=5 frame -> the next cycle shows `ser_valid`=0, `dat_out`=00, `cnt_ready`=1, and `done` never pulses.
- Change `cnt_in` from 2 to 7 at T+3 with valid low -> the frame continues as pattern 8'b0000_0011 and the block is not accepted until IDLE.
